div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative multi-cycle integer divider (restoring, radix-2, one quotient bit per cycle) placed beside the execute-stage ALU.
- Takes the same rs1/rs2 operands the ALU sees, and returns quotient and remainder to the writeback mux or to the HI/LO register pair.
- Removes the single-cycle combinational divide from the ALU critical path.
- The pipeline stalls on oBusy and captures results on oDone.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, synchronous, active-high
- iStart  in  1  request; sampled only while the FSM is in IDLE
- iSigned  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- iKill  in  1  abort the operation in flight (pipeline flush)
- iDividend  in  WIDTH  rs1 operand
- iDivisor  in  WIDTH  rs2 operand
- oBusy  out  1  operation in flight; the pipeline stalls while this is high
- oDone  out  1  single-cycle pulse; results valid
- oDivZero  out  1  last completed operation had divisor == 0
- oQuotient  out  WIDTH  registered quotient; held until the next completion
- oRemainder  out  WIDTH  registered remainder; held until the next completion

Behaviour:
- Clocking and reset
  - One clock, iCLK.
  - Reset is synchronous and active-high on iRST, evaluated at the iCLK edge.
  - iRST has priority over all other inputs.
  - Reset values: state IDLE; oBusy, oDone and oDivZero = 0; oQuotient and oRemainder = 0; counter and working registers = 0.
- FSM states: IDLE, CALC, FIN.
- IDLE with iStart = 1 at edge k:
  - Divisor == 0 (fast path):
    - oQuotient = all ones; oRemainder = iDividend; oDivZero = 1.
    - oDone = 1 for the cycle after edge k; state stays IDLE; latency 1.
  - iSigned, iDividend = 0x80000000, iDivisor = 0xFFFFFFFF (fast path):
    - oQuotient = 0x80000000; oRemainder = 0; oDivZero = 0.
    - oDone pulse as for divide-by-zero; latency 1.
  - Otherwise (normal path):
    - Latch the absolute values when iSigned, else the raw values.
    - Latch the quotient sign = sign(dividend) XOR sign(divisor).
    - Latch the remainder sign = sign(dividend).
    - Clear the partial remainder; counter = WIDTH-1.
    - oBusy = 1; go to CALC.
- CALC, one edge per iteration:
  - Shift {partial remainder, dividend} left by 1 and trial-subtract the divisor.
  - The trial subtraction is WIDTH+1 bits wide so no carry is lost.
  - Non-negative result: keep it and set quotient bit = 1. Negative result: restore and set bit = 0.
  - Counter decrements; after the iteration with counter == 0, go to FIN.
  - CALC therefore lasts exactly WIDTH edges (k+1 .. k+WIDTH).
- FIN, edge k+WIDTH+1:
  - Apply sign correction: two's-complement negate the quotient/remainder where the latched sign is set.
  - Register oQuotient and oRemainder; oDivZero = 0.
  - oDone = 1; oBusy = 0; state = IDLE.
  - Normal-path latency is WIDTH+1 = 33 edges from the accepting edge.
- oDone
  - oDone is high for exactly one cycle and clears at the next edge unless another fast-path completion occurs.
  - A new iStart is accepted in the cycle in which oDone is high, because the state is already IDLE.
- Ignored and abort inputs
  - iStart is ignored in CALC and FIN; it is not queued.
  - iKill in CALC or FIN: go to IDLE, oBusy = 0, no oDone, output registers unchanged.
  - iKill in IDLE has no effect.
  - iKill and iStart together in IDLE: the start is discarded.
- Operand stability: operands are captured at the accepting edge only; later changes have no effect.
- Reset mid-operation: back to IDLE next edge, all outputs at their reset values, no oDone.
- Unsigned mode: operands are treated as unsigned; no overflow case exists.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, CALC, FIN);
  - the DIV/DIVU/REM/REMU op-select constants shared with the ALU control decoder;
  - the div-by-zero quotient constant (all ones).
- One natural sub-module, div_step: a combinational single iteration.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once inside div_unit.

Test Plan:
- Unsigned 100 / 7 (iSigned = 0) -> oDone exactly 33 cycles after start; Q = 14, R = 2; oBusy high for 33 cycles.
- Signed -7 / 2 -> Q = 0xFFFFFFFD (-3), R = 0xFFFFFFFF (-1); signed 7 / -2 -> Q = -3, R = 1.
- Divide by zero, dividend 0x1234 -> oDone one cycle after start; Q = 0xFFFFFFFF, R = 0x1234, oDivZero = 1.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> one-cycle latency; Q = 0x80000000, R = 0.
- Back-to-back: iStart reasserted while oDone is high -> second operation accepted.
  - Second result (0xFFFFFFFF / 0x10 unsigned) -> Q = 0x0FFFFFFF, R = 0xF.
  - An iStart pulsed during CALC is ignored.
- iKill at CALC cycle 10, then iRST at CALC cycle 5 of a new operation:
  - iKill -> no oDone, previous outputs held.
  - iRST -> outputs cleared to 0, oBusy = 0 the next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider and the ALU control decoder.
// Holds the FSM state type, the divide op-select codes and the divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } divState_t;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  localparam int unsigned         DIV_XLEN   = 32;
  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial-subtract the divisor,
// and keep the difference only when it did not go negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] partRem,
  input  logic             dividendMsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // partRem < divisor always holds, so WIDTH+1 bits cover both the shift and the borrow
  always_comb begin
    shifted = {partRem, dividendMsb};
    trial   = shifted - {1'b0, divisor};
    qBit    = ~trial[WIDTH];
    nextRem = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider beside the execute-stage ALU.
// Divide-by-zero and signed overflow complete in one edge; other operations take WIDTH+1 edges.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic             iKill,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  divState_t        state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] partRem, quo, dvs;
  logic [WIDTH-1:0] remNext, absDvd, absDvs;
  logic             qBit, qNeg, rNeg;
  logic             dvdNeg, dvsNeg, divZero, sgnOvf;

  div_step #(.WIDTH(WIDTH)) uStep (
    .partRem    (partRem),
    .dividendMsb(quo[WIDTH-1]),
    .divisor    (dvs),
    .nextRem    (remNext),
    .qBit       (qBit)
  );

  always_comb begin
    dvdNeg  = iSigned & iDividend[WIDTH-1];
    dvsNeg  = iSigned & iDivisor[WIDTH-1];
    absDvd  = dvdNeg ? -iDividend : iDividend;
    absDvs  = dvsNeg ? -iDivisor : iDivisor;
    divZero = (iDivisor == '0);
    sgnOvf  = iSigned && (iDividend == MIN_NEG) && (iDivisor == '1);
  end

  always_comb begin
    stateNext = state;
    oBusy     = (state != IDLE);
    case (state)
      IDLE: if (iStart && !iKill && !divZero && !sgnOvf) stateNext = CALC;
      CALC: begin
        if (iKill)            stateNext = IDLE;
        else if (cnt == '0)   stateNext = FIN;
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // The quotient register starts as |dividend| and shifts quotient bits in from the right
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt        <= '0;
      partRem    <= '0;
      quo        <= '0;
      dvs        <= '0;
      qNeg       <= 1'b0;
      rNeg       <= 1'b0;
      oDone      <= 1'b0;
      oDivZero   <= 1'b0;
      oQuotient  <= '0;
      oRemainder <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart && !iKill) begin
            if (divZero) begin
              oQuotient  <= WIDTH'(DIV_ZERO_Q);
              oRemainder <= iDividend;
              oDivZero   <= 1'b1;
              oDone      <= 1'b1;
            end else if (sgnOvf) begin
              oQuotient  <= MIN_NEG;
              oRemainder <= '0;
              oDivZero   <= 1'b0;
              oDone      <= 1'b1;
            end else begin
              quo     <= absDvd;
              dvs     <= absDvs;
              qNeg    <= dvdNeg ^ dvsNeg;
              rNeg    <= dvdNeg;
              partRem <= '0;
              cnt     <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          if (!iKill) begin
            partRem <= remNext;
            quo     <= {quo[WIDTH-2:0], qBit};
            cnt     <= cnt - 1'b1;
          end
        end
        FIN: begin
          if (!iKill) begin
            oQuotient  <= qNeg ? -quo : quo;
            oRemainder <= rNeg ? -partRem : partRem;
            oDivZero   <= 1'b0;
            oDone      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random operations against an
// arithmetic reference, and hand sequences for ignored start, kill and mid-operation reset.
module tb_div_unit;

  logic        iCLK = 1'b0;
  logic        iRST, iStart, iSigned, iKill;
  logic [31:0] iDividend, iDivisor;
  logic        oBusy, oDone, oDivZero;
  logic [31:0] oQuotient, oRemainder;

  int nChecks = 0;
  int nPass   = 0;

  div_unit #(.WIDTH(32)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iKill     (iKill),
    .iDividend (iDividend),
    .iDivisor  (iDivisor),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oDivZero  (oDivZero),
    .oQuotient (oQuotient),
    .oRemainder(oRemainder)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference result from plain integer arithmetic (truncating division, remainder takes dividend sign)
  task automatic refDiv(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output bit dz);
    int sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // Called at a negedge; returns at the negedge where oDone is seen (or after the bound)
  task automatic runOp(input bit s, input logic [31:0] a, input logic [31:0] b, input int pokeAt,
                       output int lat, output int busyCnt);
    iSigned = s; iDividend = a; iDivisor = b; iStart = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    iSigned = 1'($urandom); iDividend = $urandom; iDivisor = $urandom;
    lat = 0; busyCnt = 0;
    while (!oDone && lat < 60) begin
      if (oBusy) busyCnt++;
      if (lat == pokeAt) begin
        iStart = 1'b1; iDivisor = 32'd0;
      end else begin
        iStart = 1'b0;
      end
      @(negedge iCLK);
      lat++;
    end
    iStart = 1'b0;
  endtask

  task automatic checkOp(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int pokeAt);
    logic [31:0] q, r;
    bit dz;
    int lat, busyCnt, expLat;
    refDiv(s, a, b, q, r, dz);
    expLat = (dz || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33;
    runOp(s, a, b, pokeAt, lat, busyCnt);
    chk({tag, ".done"}, 32'(oDone), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(expLat));
    chk({tag, ".busyCycles"}, 32'(busyCnt), 32'(expLat));
    chk({tag, ".q"}, oQuotient, q);
    chk({tag, ".r"}, oRemainder, r);
    chk({tag, ".divZero"}, 32'(oDivZero), 32'(dz));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prevQ, prevR, a, b;
    int seen, lat, busyCnt;
    bit s;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2,          1'b0};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0};
    tbl[3] = '{1'b0, 32'h1234,       32'd0,        32'hFFFF_FFFF,  32'h1234,       1'b1};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF,  32'hF,          1'b0};
    tbl[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000,  1'b0};
    tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE,  1'b0};
    tbl[8] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'd0,          1'b0};
    tbl[9] = '{1'b1, 32'd0,          32'd5,        32'd0,          32'd0,          1'b0};

    iRST = 1'b1; iStart = 1'b0; iSigned = 1'b0; iKill = 1'b0;
    iDividend = '0; iDivisor = '0;
    repeat (3) @(negedge iCLK);
    chk("reset.busy", 32'(oBusy), 32'd0);
    chk("reset.done", 32'(oDone), 32'd0);
    chk("reset.divZero", 32'(oDivZero), 32'd0);
    chk("reset.q", oQuotient, 32'd0);
    chk("reset.r", oRemainder, 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Table entries run back-to-back: each start is raised while the previous oDone is high
    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i].sgn, tbl[i].a, tbl[i].b, -1, lat, busyCnt);
      chk($sformatf("vec%0d.done", i), 32'(oDone), 32'd1);
      chk($sformatf("vec%0d.latency", i), 32'(lat), (tbl[i].dz || i == 4) ? 32'd0 : 32'd33);
      chk($sformatf("vec%0d.busyCycles", i), 32'(busyCnt), (tbl[i].dz || i == 4) ? 32'd0 : 32'd33);
      chk($sformatf("vec%0d.q", i), oQuotient, tbl[i].q);
      chk($sformatf("vec%0d.r", i), oRemainder, tbl[i].r);
      chk($sformatf("vec%0d.divZero", i), 32'(oDivZero), 32'(tbl[i].dz));
    end

    // A start pulsed during CALC must neither disturb the result nor be queued
    checkOp("pokeCalc", 1'b0, 32'd100, 32'd7, 5);
    seen = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (oDone || oBusy) seen++;
    end
    chk("pokeCalc.notQueued", 32'(seen), 32'd0);

    // Kill at CALC iteration 10
    prevQ = oQuotient; prevR = oRemainder;
    iSigned = 1'b0; iDividend = 32'd1000; iDivisor = 32'd3; iStart = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (9) @(negedge iCLK);
    chk("kill.busyBefore", 32'(oBusy), 32'd1);
    iKill = 1'b1;
    @(negedge iCLK);
    iKill = 1'b0;
    chk("kill.busy", 32'(oBusy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone) seen++;
    end
    chk("kill.noDone", 32'(seen), 32'd0);
    chk("kill.qHeld", oQuotient, prevQ);
    chk("kill.rHeld", oRemainder, prevR);

    // Kill together with start in IDLE discards the start
    iSigned = 1'b0; iDividend = 32'd50; iDivisor = 32'd0; iStart = 1'b1; iKill = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0; iKill = 1'b0;
    chk("killStart.busy", 32'(oBusy), 32'd0);
    chk("killStart.done", 32'(oDone), 32'd0);
    chk("killStart.qHeld", oQuotient, prevQ);

    // Reset at CALC cycle 5 after a divide-by-zero left oDivZero set
    checkOp("preReset", 1'b0, 32'hABCD, 32'd0, -1);
    iSigned = 1'b1; iDividend = 32'd12345; iDivisor = 32'd17; iStart = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (4) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("midReset.busy", 32'(oBusy), 32'd0);
    chk("midReset.done", 32'(oDone), 32'd0);
    chk("midReset.divZero", 32'(oDivZero), 32'd0);
    chk("midReset.q", oQuotient, 32'd0);
    chk("midReset.r", oRemainder, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone) seen++;
    end
    chk("midReset.noDone", 32'(seen), 32'd0);
    checkOp("postReset", 1'b1, 32'hFFFF_FC00, 32'd9, -1);

    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2: begin
          b = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
        end
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      checkOp($sformatf("rand%0d", n), s, a, b, -1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
